ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM; each access is a
// non-pipelined IDLE -> ACCESS -> RESP sequence with round-robin or fixed priority.
module ram_arbiter #(
  parameter int unsigned DEPTH      = 256,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_addr,
  output logic        ram_wr,
  output logic        ram_rd,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;
  logic   grant_q;  // 0 = m0, 1 = m1
  logic   last_q;
  logic   oor_q;

  logic        any_req;
  logic        sel;
  logic        sel_wr;
  logic        sel_in_range;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin
    any_req = m0_req | m1_req;
    if (FIXED_PRIO) begin
      sel = ~m0_req;
    end else if (m0_req && m1_req) begin
      sel = ~last_q;
    end else begin
      sel = ~m0_req;
    end
    sel_wr       = sel ? m1_wr : m0_wr;
    sel_addr     = sel ? m1_addr : m0_addr;
    sel_wdata    = sel ? m1_wdata : m0_wdata;
    sel_in_range = sel_addr < DEPTH;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q   <= 1'b0;
      last_q    <= 1'b1;  // m0 wins the first tie
      oor_q     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wr    <= 1'b0;
      ram_rd    <= 1'b0;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q   <= sel;
            last_q    <= sel;
            oor_q     <= ~sel_in_range;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            ram_wr    <= sel_in_range & sel_wr;
            ram_rd    <= sel_in_range & ~sel_wr;
          end
        end
        StAccess: begin
          ram_wr <= 1'b0;
          ram_rd <= 1'b0;
          // ram_rd is only high for an in-range read, so it gates the capture
          if (!grant_q) begin
            m0_ack <= 1'b1;
            m0_err <= oor_q;
            if (oor_q) m0_rdata <= '0;
            else if (ram_rd) m0_rdata <= ram_rdata;
          end else begin
            m1_ack <= 1'b1;
            m1_err <= oor_q;
            if (oor_q) m1_rdata <= '0;
            else if (ram_rd) m1_rdata <= ram_rdata;
          end
        end
        StResp: begin
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed accesses push expected acks,
// a negedge monitor pops and compares; a second instance covers fixed priority.
module tb_ram_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        m0_req, m0_wr, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_wr, ram_rd, busy;

  logic        f_m0_req, f_m1_req, f_m0_ack, f_m1_ack, f_m0_err, f_m1_err;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_ram_addr, f_ram_wdata;
  logic        f_ram_wr, f_ram_rd, f_busy;

  ram_arbiter #(.DEPTH(256), .FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  ram_arbiter #(.DEPTH(256), .FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_req(f_m0_req), .m0_wr(1'b0), .m0_addr(32'd3), .m0_wdata(32'd0),
    .m0_ack(f_m0_ack), .m0_err(f_m0_err), .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_wr(1'b0), .m1_addr(32'd4), .m1_wdata(32'd0),
    .m1_ack(f_m1_ack), .m1_err(f_m1_err), .m1_rdata(f_m1_rdata),
    .ram_addr(f_ram_addr), .ram_wr(f_ram_wr), .ram_rd(f_ram_rd), .ram_wdata(f_ram_wdata),
    .ram_rdata(32'd0), .busy(f_busy)
  );

  // RAM model: acts on negedge, drives read data only while ram_rd is high
  logic [31:0] mem [0:255];
  logic [31:0] ram_q;
  always @(negedge clock) begin
    if (ram_wr && ram_addr < 256) mem[ram_addr[7:0]] <= ram_wdata;
    if (ram_rd && ram_addr < 256) ram_q <= mem[ram_addr[7:0]];
  end
  assign ram_rdata = ram_rd ? ram_q : 'z;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          m;
    logic        err;
    logic [31:0] rdata;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acks = 0;
  int   f0 = 0;
  int   f1 = 0;
  bit   watch_oor = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual no ack required ack within bound", name);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (m0_ack || m1_ack) begin
        exp_t e;
        int   m;
        m = m1_ack ? 1 : 0;
        n_acks++;
        ack_cyc.push_back(cyc);
        check("single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: actual ack from m%0d required none", m);
        end else begin
          e = sb.pop_front();
          check("grant_master", m, e.m);
          check("ack_err", m ? m1_err : m0_err, e.err);
          if (e.chk_rd) check("ack_rdata", m ? m1_rdata : m0_rdata, e.rdata);
        end
      end
      if (watch_oor) begin
        check("oor_no_rd", ram_rd, 32'd0);
        check("oor_no_wr", ram_wr, 32'd0);
      end
      if (f_m0_ack) f0++;
      if (f_m1_ack) f1++;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ram_wr"}, ram_wr, 0);
    check({tag, "_ram_rd"}, ram_rd, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_acks"}, {m0_ack, m1_ack, m0_err, m1_err}, 0);
    check({tag, "_m0_rdata"}, m0_rdata, 0);
    check({tag, "_m1_rdata"}, m1_rdata, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One master access from an idle bus: latency from issue to visible ack is 2 cycles
  task automatic access(input int m, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic err,
                        input logic [31:0] rd, input bit chk_rd);
    exp_t e;
    int   c0;
    bit   got;
    @(posedge clock);
    #1;
    e.m = m; e.err = err; e.rdata = rd; e.chk_rd = chk_rd;
    sb.push_back(e);
    if (m == 0) begin
      m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
    end
    c0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clock);
      #1;
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) got = 1'b1;
    end
    if (m == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
    if (!got) timeout("ack_timeout");
    else check("ack_latency", cyc - c0, 2);
  endtask

  initial begin
    int k;
    int na;
    bit got;
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    f_m0_req = 0; f_m1_req = 0;
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    check("reset_fp_busy", f_busy, 0);
    @(negedge clock) reset = 1'b0;

    // Both requesting from reset: m0, m1, m0, m1, three cycles apart
    @(posedge clock);
    #1;
    ack_cyc.delete();
    m0_req = 1; m0_wr = 1; m0_addr = 10; m0_wdata = 32'hAAAA_0010;
    m1_req = 1; m1_wr = 1; m1_addr = 11; m1_wdata = 32'hBBBB_0011;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.m = i % 2; e.err = 0; e.rdata = 0; e.chk_rd = 0;
      sb.push_back(e);
    end
    k = 0;
    for (int i = 0; i < 30 && k < 4; i++) begin
      @(posedge clock);
      #1;
      if (m0_ack || m1_ack) k++;
    end
    m0_req = 0;
    m1_req = 0;
    if (k < 4) timeout("rr_acks");
    @(negedge clock);
    #1;
    if (ack_cyc.size() != 4) check("rr_ack_count", ack_cyc.size(), 4);
    else for (int i = 1; i < 4; i++) check("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 3);

    access(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    access(0, 0, 5, 0, 0, 32'hDEAD_BEEF, 1);
    access(0, 1, 7, 32'h1234_5678, 0, 0, 0);
    access(1, 0, 7, 0, 0, 32'h1234_5678, 1);
    access(1, 0, 11, 0, 0, 32'hBBBB_0011, 1);
    access(0, 0, 10, 0, 0, 32'hAAAA_0010, 1);
    access(0, 1, 255, 32'hCAFE_F00D, 0, 0, 0);
    access(0, 0, 255, 0, 0, 32'hCAFE_F00D, 1);

    watch_oor = 1'b1;
    access(1, 0, 256, 0, 1, 0, 1);
    access(0, 1, 32'hFFFF_FFFF, 32'h0000_1234, 1, 0, 1);
    watch_oor = 1'b0;

    // Reset pulsed during ACCESS of an m0 read aborts it
    @(posedge clock);
    #1;
    na = n_acks;
    m0_req = 1; m0_wr = 0; m0_addr = 5;
    @(posedge clock);
    #1;
    check("abort_busy", busy, 1);
    check("abort_rd_strobe", ram_rd, 1);
    #2 reset = 1'b1;
    #1;
    m0_req = 0;
    check_zero("abort");
    @(negedge clock) reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("abort_no_ack", n_acks, na);
    check("abort_idle", busy, 0);
    access(0, 0, 5, 0, 0, 32'hDEAD_BEEF, 1);

    // Fixed priority: m0 holds the bus while requesting, m1 served only after
    @(posedge clock);
    #1;
    f_m0_req = 1;
    f_m1_req = 1;
    repeat (15) @(posedge clock);
    #1;
    check("fp_m1_starved", f1, 0);
    check("fp_m0_grants", f0 >= 4, 1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clock);
      #1;
      if (f_m0_ack) got = 1'b1;
    end
    f_m0_req = 0;
    if (!got) timeout("fp_m0_ack");
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clock);
      #1;
      if (f_m1_ack) got = 1'b1;
    end
    f_m1_req = 0;
    if (!got) timeout("fp_m1_ack");
    @(negedge clock);
    #1;
    check("fp_m1_after_drop", f1, 1);
    check("fp_m1_err", f_m1_err, 0);

    repeat (3) @(posedge clock);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1);
  end

endmodule
